// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: owns the PC, fetches over a req/gnt/rvalid handshake, and holds instr until it is retired.
// Optional performance counters (retired_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch,
  input  logic            zero,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     stall_cnt
`endif
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID, S_HALT} state_t;

  state_t          state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;
  logic            req_reg;
  logic            valid_reg;
  logic            fault_reg;
  logic [XLEN-1:0] pc_next;
  logic            taken;

  assign taken    = branch & zero;
  assign pc_plus4 = pc_reg + XLEN'(4);
  assign pc_next  = taken ? (pc_reg + imm_ext) : pc_plus4;

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign fetch_fault = fault_reg;

  // Outputs are registered; req_reg is low for the first cycle after reset,
  // so a grant is only honoured once the request is actually visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_PC;
      instr_reg <= '0;
      req_reg   <= 1'b0;
      valid_reg <= 1'b0;
      fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_reg && imem_gnt) begin
            req_reg   <= 1'b0;
            state_reg <= S_WAIT;
          end else begin
            req_reg <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_reg <= imem_rdata;
            valid_reg <= 1'b1;
            state_reg <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_ready) begin
            pc_reg    <= pc_next;
            valid_reg <= 1'b0;
            if (pc_next[1:0] != 2'b00) begin
              fault_reg <= 1'b1;
              state_reg <= S_HALT;
            end else begin
              req_reg   <= 1'b1;
              state_reg <= S_REQ;
            end
          end
        end
        S_HALT: begin
          req_reg   <= 1'b0;
          valid_reg <= 1'b0;
          fault_reg <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] retired_cnt_reg;
  logic [31:0] stall_cnt_reg;

  assign retired_cnt = retired_cnt_reg;
  assign stall_cnt   = stall_cnt_reg;

  // Both counters naturally freeze in S_HALT since neither condition can hold there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_reg <= '0;
      stall_cnt_reg   <= '0;
    end else begin
      if (state_reg == S_VALID && instr_ready)
        retired_cnt_reg <= retired_cnt_reg + 32'd1;
      if ((state_reg == S_REQ && req_reg && !imem_gnt) ||
          (state_reg == S_WAIT && !imem_rvalid))
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: behavioural memory responder plus a PC-sequence reference model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] imm_ext = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .zero(zero), .imm_ext(imm_ext),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Responder configuration
  logic        resp_en = 1'b1;
  logic        rand_lat = 1'b0;
  logic        noise = 1'b0;
  logic        fixed_word = 1'b0;
  int          gnt_dly = 0;
  int          rv_dly = 0;
  logic        stale_rv = 1'b0;
  logic [31:0] stale_data = 32'hDEAD_BEEF;
  int          phase = 0;
  logic [31:0] gaddr = '0;
  logic [31:0] gq[$];

  // Memory responder: grants after a delay, returns data after a further delay.
  initial begin
    int gcnt, rcnt;
    logic [31:0] req_addr;
    logic rv_prev;
    gcnt = 0; rcnt = 0; req_addr = '0; rv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rv_prev && rst_n) chk("valid_after_rvalid", {31'd0, instr_valid}, 32'd1);
      rv_prev = 1'b0;
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (!rst_n || !resp_en) begin
        phase = 0;
        imem_rvalid = stale_rv;
        if (stale_rv) imem_rdata = stale_data;
      end else begin
        if (phase == 0 && imem_req) begin
          gcnt = rand_lat ? int'($urandom_range(0, 3)) : gnt_dly;
          rcnt = rand_lat ? int'($urandom_range(0, 3)) : rv_dly;
          req_addr = imem_addr;
          phase = 1;
        end else if (phase == 1) begin
          chk("addr_stable", imem_addr, req_addr);
          chk("req_held", {31'd0, imem_req}, 32'd1);
        end
        if (phase == 1) begin
          if (gcnt == 0) begin
            imem_gnt = 1'b1;
            gaddr = req_addr;
            gq.push_back(req_addr);
            phase = 2;
          end else begin
            gcnt--;
            if (noise) imem_rvalid = 1'($urandom_range(0, 1));
          end
        end else if (phase == 2) begin
          chk("req_low_wait", {31'd0, imem_req}, 32'd0);
          if (rcnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata = fixed_word ? 32'h0050_0093 : mem_word(gaddr);
            rv_prev = 1'b1;
            phase = 0;
          end else begin
            rcnt--;
            if (noise) imem_gnt = 1'($urandom_range(0, 1));
          end
        end else if (noise) begin
          imem_rvalid = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic [31:0] exp_pc = '0;

  task automatic do_reset();
    instr_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
  endtask

  // Waits for the instruction at exp_pc, optionally stalls decode, then retires it.
  task automatic retire(input logic br, input logic z, input logic [31:0] imm,
                        input logic [31:0] nxt, input int stall);
    int t;
    logic [31:0] exp_instr;
    t = 0;
    while (!instr_valid && t < 300) begin
      instr_ready = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1));
      zero = 1'($urandom_range(0, 1));
      imm_ext = $urandom | 32'h1;
      @(negedge clk);
      t++;
    end
    instr_ready = 1'b0;
    if (!instr_valid) begin
      chk("fetch_timeout", {31'd0, instr_valid}, 32'd1);
      return;
    end
    exp_instr = fixed_word ? 32'h0050_0093 : mem_word(exp_pc);
    chk("ret_pc", pc, exp_pc);
    chk("ret_fetch_addr", gaddr, exp_pc);
    chk("ret_instr", instr, exp_instr);
    chk("ret_pc_plus4", pc_plus4, exp_pc + 32'd4);
    for (int s = 0; s < stall; s++) begin
      branch = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_pc", pc, exp_pc);
      chk("stall_instr", instr, exp_instr);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    branch = br;
    zero = z;
    imm_ext = imm;
    @(negedge clk);
    instr_ready = 1'b0;
    $display("retire pc=%h instr=%h br=%0d z=%0d imm=%h next=%h", exp_pc, instr, br, z, imm, nxt);
    exp_pc = nxt;
    chk("valid_drop", {31'd0, instr_valid}, 32'd0);
    chk("next_pc", pc, nxt);
    chk("fault_state", {31'd0, fetch_fault}, {31'd0, (nxt[1:0] != 2'b00)});
  endtask

  typedef struct {
    logic        br;
    logic        z;
    logic [31:0] imm;
    logic [31:0] nxt;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int last, npulse, t;
    logic [31:0] imm, nxt;
    logic br, z;

    tbl[0] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0004};
    tbl[1] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0008};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0008, 32'h0000_0010};
    tbl[3] = '{1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0000, 32'h0000_000C};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFF4, 32'h0000_0000};
    tbl[6] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    tbl[7] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000};
    tbl[8] = '{1'b1, 1'b1, 32'h0000_0010, 32'h0000_0010};
    tbl[9] = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0000_0014};

    // Zero-wait fetch with instr_ready held high
    do_reset();
    fixed_word = 1'b1;
    gq.delete();
    instr_ready = 1'b1;
    branch = 1'b0;
    last = -1;
    npulse = 0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        chk("zw_instr", instr, 32'h0050_0093);
        if (last >= 0) chk("zw_spacing", 32'(c - last), 32'd3);
        last = c;
        npulse++;
      end
    end
    instr_ready = 1'b0;
    chk("zw_pulses", 32'(npulse), 32'd4);
    chk("zw_addr0", (gq.size() > 0) ? gq[0] : 32'hFFFF_FFFF, 32'h0);
    chk("zw_addr1", (gq.size() > 1) ? gq[1] : 32'hFFFF_FFFF, 32'h4);
    chk("zw_addr2", (gq.size() > 2) ? gq[2] : 32'hFFFF_FFFF, 32'h8);
    fixed_word = 1'b0;

    // Variable latency: gnt after 2 cycles, rvalid after 3 more
    do_reset();
    gnt_dly = 2;
    rv_dly = 3;
    retire(1'b0, 1'b0, 32'h0, 32'h4, 0);

    // Table-driven branch / wrap vectors
    do_reset();
    gnt_dly = 0;
    rv_dly = 1;
    for (int i = 0; i < 10; i++)
      retire(tbl[i].br, tbl[i].z, tbl[i].imm, tbl[i].nxt, (i == 3) ? 4 : 0);

    // Randomized run against the PC reference model
    rand_lat = 1'b1;
    noise = 1'b1;
    for (int i = 0; i < 40; i++) begin
      br = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      imm = $urandom & 32'h0000_03FC;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      nxt = (br && z) ? exp_pc + imm : exp_pc + 32'd4;
      retire(br, z, imm, nxt, int'($urandom_range(0, 2)));
    end

    // Misaligned target halts the fetch unit
    retire(1'b1, 1'b1, 32'h20 - exp_pc, 32'h20, 0);
    retire(1'b1, 1'b1, 32'h6, 32'h26, 0);
    for (int c = 0; c < 4; c++) begin
      instr_ready = 1'b1;
      branch = 1'b1;
      zero = 1'b1;
      @(negedge clk);
      chk("halt_fault", {31'd0, fetch_fault}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_pc", pc, 32'h26);
    end
    instr_ready = 1'b0;
    rand_lat = 1'b0;
    noise = 1'b0;

    // Reset during S_WAIT, stale rvalid after release
    do_reset();
    gnt_dly = 0;
    rv_dly = 8;
    t = 0;
    while (phase != 2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mid_wait_reached", 32'(phase), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    resp_en = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stale_rv = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stale_valid", {31'd0, instr_valid}, 32'd0);
      chk("stale_instr", instr, 32'd0);
    end
    chk("stale_req", {31'd0, imem_req}, 32'd1);
    chk("stale_addr", imem_addr, 32'd0);
    stale_rv = 1'b0;
    resp_en = 1'b1;
    exp_pc = '0;
    rv_dly = 1;
    retire(1'b0, 1'b0, 32'h0, 32'h4, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
